watch_core_param: RTL

WATCH_CORE_PARAM -- requirements
Module: watch_core_param

---
 rtl/watch_core_param.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/watch_core_param.sv
// Parameterised stopwatch/clock core: prescaled sub-second stepping up or down,
// cursor-driven field editing, and a one-shot alarm on stepped arrival at hh:mm:00.00.
module watch_core_param #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int SUB_MOD   = 100,
    parameter int HOUR_MOD  = 24,
    parameter int INIT_HOUR = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        run,
    input  logic                        dir,
    input  logic                        edit_en,
    input  logic                        field_l,
    input  logic                        field_r,
    input  logic                        inc,
    input  logic                        dec,
    input  logic [$clog2(HOUR_MOD)-1:0] alarm_hour,
    input  logic [5:0]                  alarm_min,
    input  logic                        alarm_en,
    output logic [$clog2(SUB_MOD)-1:0]  sub,
    output logic [5:0]                  sec,
    output logic [5:0]                  min,
    output logic [$clog2(HOUR_MOD)-1:0] hour,
    output logic [1:0]                  cursor,
    output logic                        tick,
    output logic                        alarm_hit
);
    localparam int SW    = $clog2(SUB_MOD);
    localparam int HW    = $clog2(HOUR_MOD);
    localparam int PRESC = CLK_HZ / TICK_HZ;
    localparam int PW    = $clog2(PRESC);

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
    localparam logic [SW-1:0] SUB_LAST   = SW'(SUB_MOD - 1);
    localparam logic [HW-1:0] HOUR_LAST  = HW'(HOUR_MOD - 1);
    localparam logic [HW-1:0] HOUR_INIT  = HW'(INIT_HOUR);

    logic [PW-1:0] presc;
    logic          step;
    logic          edit_op;
    logic          alarm_match;
    logic [SW-1:0] sub_n;
    logic [5:0]    sec_n;
    logic [5:0]    min_n;
    logic [HW-1:0] hour_n;

    // tick is the step itself, so fields change on the edge that ends the tick cycle
    assign step    = run & ~edit_en & ~clear & (presc == PRESC_LAST);
    assign tick    = step;
    assign edit_op = edit_en & (inc ^ dec);

    always_comb begin
        sub_n  = sub;
        sec_n  = sec;
        min_n  = min;
        hour_n = hour;
        if (step && !dir) begin
            if (sub != SUB_LAST) sub_n = sub + SW'(1);
            else begin
                sub_n = '0;
                if (sec != 6'd59) sec_n = sec + 6'd1;
                else begin
                    sec_n = '0;
                    if (min != 6'd59) min_n = min + 6'd1;
                    else begin
                        min_n  = '0;
                        hour_n = (hour == HOUR_LAST) ? '0 : hour + HW'(1);
                    end
                end
            end
        end else if (step && dir) begin
            if (sub != '0) sub_n = sub - SW'(1);
            else begin
                sub_n = SUB_LAST;
                if (sec != '0) sec_n = sec - 6'd1;
                else begin
                    sec_n = 6'd59;
                    if (min != '0) min_n = min - 6'd1;
                    else begin
                        min_n  = 6'd59;
                        hour_n = (hour == '0) ? HOUR_LAST : hour - HW'(1);
                    end
                end
            end
        end else if (edit_op) begin
            // edits wrap within the selected field only
            case (cursor)
                2'd0: sub_n  = inc ? ((sub == SUB_LAST) ? '0 : sub + SW'(1))
                                   : ((sub == '0) ? SUB_LAST : sub - SW'(1));
                2'd1: sec_n  = inc ? ((sec == 6'd59) ? '0 : sec + 6'd1)
                                   : ((sec == '0) ? 6'd59 : sec - 6'd1);
                2'd2: min_n  = inc ? ((min == 6'd59) ? '0 : min + 6'd1)
                                   : ((min == '0) ? 6'd59 : min - 6'd1);
                default: hour_n = inc ? ((hour == HOUR_LAST) ? '0 : hour + HW'(1))
                                      : ((hour == '0) ? HOUR_LAST : hour - HW'(1));
            endcase
        end
    end

    // out-of-range alarm settings can never equal a legal field value
    assign alarm_match = step && alarm_en
                      && (alarm_hour <= HOUR_LAST) && (alarm_min <= 6'd59)
                      && (hour_n == alarm_hour) && (min_n == alarm_min)
                      && (sec_n == '0) && (sub_n == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sub       <= '0;
            sec       <= '0;
            min       <= '0;
            hour      <= HOUR_INIT;
            alarm_hit <= 1'b0;
        end else if (clear) begin
            sub       <= '0;
            sec       <= '0;
            min       <= '0;
            hour      <= HOUR_INIT;
            alarm_hit <= 1'b0;
        end else begin
            sub       <= sub_n;
            sec       <= sec_n;
            min       <= min_n;
            hour      <= hour_n;
            alarm_hit <= alarm_match;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                   presc <= '0;
        else if (clear || edit_en)   presc <= '0;
        else if (run)                presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                        cursor <= '0;
        else if (clear)                                   cursor <= '0;
        else if (field_l && !field_r && cursor != 2'd3)   cursor <= cursor + 2'd1;
        else if (field_r && !field_l && cursor != 2'd0)   cursor <= cursor - 2'd1;
    end
endmodule
